alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The module SHALL have the parameter NUM_REQ, default 2, fixed at 2 requesters; other values are unsupported.
REQ-002 The module SHALL have these ports, one per line as name, direction, width, meaning:
- clk  input  1  sole clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  2  requester i has an operation pending.
- req_ready  output  2  requester i's operation is accepted this cycle.
- req_op  input  2 x alu_op_t  ALU operation per requester.
- req_a  input  2 x word_t  operand A per requester.
- req_b  input  2 x word_t  operand B per requester.
- rsp_valid  output  1  response held.
- rsp_ready  input  1  consumer takes the response.
- rsp_id  output  1  index of the requester that owns the response.
- rsp_result  output  word_t  ALU result.
- rsp_zero  output  1  ALU zero flag.
- grant_cnt  output  2 x 32  accepted-operation counters; see REQ-017.
REQ-003 One clock (clk); reset rst is synchronous and active-high.

Function
REQ-004 FSM states: IDLE, EXEC, RESP.
REQ-005 IDLE:
- grant to one valid requester by round-robin: priority to the requester not granted last.
- req_ready is asserted only for the granted index and is combinational from req_valid and state.
- On grant, latch op/a/b and the id, then go to EXEC.
- With no request valid, stay in IDLE.
REQ-006 req_ready SHALL be 0 in EXEC and RESP.
REQ-007 At most one bit of req_ready SHALL be set in any cycle.
REQ-008 EXEC:
- the internal ALU sees the latched operands.
- result and zero are registered at the end of the cycle.
- next state is RESP.
REQ-009 RESP:
- rsp_valid=1.
- rsp_id, rsp_result and rsp_zero are stable until rsp_valid and rsp_ready are both high; then go to IDLE.
REQ-010 Latency: operation accepted in cycle N gives rsp_valid in cycle N+2, or later only under backpressure.
REQ-011 Throughput: maximum one operation per 3 cycles; there is no acceptance in the cycle of the response handshake.
REQ-012 When rsp_ready is held low, the FSM stays in RESP indefinitely with outputs unchanged, and no request is accepted.
REQ-013 If both requesters are valid continuously, grants SHALL alternate 0,1,0,1.
REQ-014 A requester dropping req_valid before grant SHALL have no effect; there is no latching of ungranted requests.

Reset
REQ-015 While rst=1 at a clock edge:
- state goes to IDLE.
- rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0.
- the last-grant register is set to 1, so requester 0 wins first.
- grant_cnt goes to 0.
REQ-016 Reset in EXEC or RESP SHALL discard the in-flight operation, with no response produced; req_ready=0 during any cycle where rst=1.

Configuration
REQ-017 With macro ALU_ARBITER_STATS_EN defined:
- grant_cnt[i] increments by 1 on each accept by requester i.
- the counter saturates at 32'hFFFF_FFFF.
- Without the macro, grant_cnt is constant 0 and no counter flops are built.

Structure
REQ-018 alu_op_t and word_t (32-bit) SHALL come from riscv_32i_defs_pkg.
REQ-019 The FSM state enum SHALL be local to the module and SHALL NOT be added to the package.
REQ-020 The block SHALL instantiate the existing alu as its single sub-module, driven only from the latched operand registers.
REQ-021 Verification binds SHALL observe the internal ALU ports through alu_intf.

Verification
REQ-022 Single request: req_valid=01, ADD, a=5, b=7.
- req_ready=01 in cycle 0.
- rsp_valid in cycle 2 with rsp_id=0, result=0000000C, zero=0.
REQ-023 Contention after reset: req_valid=11 held.
- grant order is 0,1,0,1.
- rsp_id sequence is 0,1,0,1.
- exactly one req_ready bit is set per grant.
REQ-024 Backpressure: SUB, a=b=3, with rsp_ready=0 for 5 cycles.
- rsp_valid is held with result=0 and zero=1 unchanged.
- req_ready=00 throughout.
- the response completes when rsp_ready=1.
REQ-025 Reset mid-operation: rst pulsed in EXEC.
- no response appears.
- the next cycle is IDLE with rsp_valid=0.
- requester 0 wins the next contention.
REQ-026 Stats, only with ALU_ARBITER_STATS_EN:
- 3 grants to requester 0 and 2 to requester 1 give grant_cnt={2,3}.
- preloading a counter to 32'hFFFF_FFFF via force and granting again leaves it at 32'hFFFF_FFFF.
- without the macro, grant_cnt stays 0.

Source files
------------

// File: rtl/riscv_32i_defs_pkg.sv
// Shared RV32I datapath types: the 32-bit machine word and the ALU operation encoding.
package riscv_32i_defs_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

endpackage

// File: rtl/alu_intf.sv
// Bundle of the ALU port signals, so monitors can observe the ALU inside its parent block.
interface alu_intf;
    import riscv_32i_defs_pkg::*;

    alu_op_t op;
    word_t   a;
    word_t   b;
    word_t   result;
    logic    zero;

    modport dut (input op, a, b, output result, zero);
    modport mon (input op, a, b, result, zero);
endinterface

// File: rtl/alu.sv
// Purely combinational RV32I ALU; shift amounts use the low five bits of operand B.
module alu
    import riscv_32i_defs_pkg::*;
(
    input  alu_op_t     op,
    input  word_t       a,
    input  word_t       b,
    output word_t       result,
    output logic        zero
);

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;

    assign a_s = a;
    assign b_s = b;

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = word_t'(a_s >>> b[4:0]);
            ALU_SLT:  result = {31'd0, a_s < b_s};
            ALU_SLTU: result = {31'd0, a < b};
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters (IDLE -> EXEC -> RESP).
// Optional per-requester grant counters are built when ALU_ARBITER_STATS_EN is defined.
module alu_arbiter
    import riscv_32i_defs_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  alu_op_t           req_op [NUM_REQ],
    input  word_t             req_a  [NUM_REQ],
    input  word_t             req_b  [NUM_REQ],
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output word_t             rsp_result,
    output logic              rsp_zero,
    output logic [31:0]       grant_cnt [NUM_REQ]
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state, state_nx;
    logic [1:0] grant;
    logic       last_grant;
    logic       id_p0;
    alu_op_t    op_p0;
    word_t      a_p0;
    word_t      b_p0;
    word_t      res_p1;
    logic       zero_p1;

    alu_intf alu_if ();

    // Both valid: the requester not served last wins; otherwise serve whoever asks.
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11)
            grant = last_grant ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid != 2'b00) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 1'b0;
        if (!rst && state == IDLE) req_ready = grant;
        if (state == RESP)         rsp_valid = 1'b1;
    end

    // Stage p0: capture the granted request
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            id_p0      <= 1'b0;
        end else if (req_ready != 2'b00) begin
            last_grant <= req_ready[1];
            id_p0      <= req_ready[1];
        end
    end

    always_ff @(posedge clk) begin
        if (req_ready != 2'b00) begin
            op_p0 <= req_op[req_ready[1]];
            a_p0  <= req_a[req_ready[1]];
            b_p0  <= req_b[req_ready[1]];
        end
    end

    assign alu_if.op = op_p0;
    assign alu_if.a  = a_p0;
    assign alu_if.b  = b_p0;

    alu u_alu (
        .op     (alu_if.op),
        .a      (alu_if.a),
        .b      (alu_if.b),
        .result (alu_if.result),
        .zero   (alu_if.zero)
    );

    // Stage p1: register the ALU result for the response
    always_ff @(posedge clk) begin
        if (rst) begin
            res_p1  <= '0;
            zero_p1 <= 1'b0;
        end else if (state == EXEC) begin
            res_p1  <= alu_if.result;
            zero_p1 <= alu_if.zero;
        end
    end

    assign rsp_id     = id_p0;
    assign rsp_result = res_p1;
    assign rsp_zero   = zero_p1;

`ifdef ALU_ARBITER_STATS_EN
    logic [31:0] grant_cnt_q [NUM_REQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst)
                grant_cnt_q[i] <= '0;
            else if (req_ready[i] && grant_cnt_q[i] != 32'hFFFF_FFFF)
                grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
        end
    end

    assign grant_cnt = grant_cnt_q;
`else
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_no_stats
        assign grant_cnt[g] = '0;
    end
`endif

endmodule
